zero_unpad: RTL and testbench
=============================

Name: zero_unpad

Overview:
Streaming inverse of the zero-insertion padder.
- Input: a zero-interleaved frame of (2*(SIZE-1)+1)^2 words in raster order.
- Output: the SIZE^2 original samples, i.e. the elements at even row and even column.
- Sits after stride-2 transposed-conv / deconv stages to restore the native grid. Also serves as the loopback checker for the padder.

Parameters:
SIZE, 5, output frame edge length; input edge length is 2*(SIZE-1)+1 (9 by default).
DATA_W, 32, width of one array element.

Ports:
clk  input  1  clock; all logic rising-edge.
reset  input  1  synchronous, active-high reset.
en  input  1  global enable; when low, no input is accepted and all state holds.
in_valid  input  1  in_data carries a valid element.
in_ready  output  1  block can accept an element this cycle.
in_data  input  DATA_W  padded-frame element, raster order (row-major).
out_valid  output  1  out_data holds a kept element.
out_ready  input  1  downstream accepts out_data.
out_data  output  DATA_W  kept element.
out_last  output  1  qualifies the final kept element of a frame (SIZE-1,SIZE-1).
frame_done  output  1  one-cycle pulse when the last padded element is accepted.
pad_err  output  1  sticky error flag; present only with the optional feature, tied 0 otherwise.

Behaviour:
- Reset (sync, reset=1 at posedge):
  - row_cnt=0, col_cnt=0.
  - out_valid=0, out_data=0, out_last=0, frame_done=0, pad_err=0.
  - Reset overrides everything, including mid-frame. A partial frame is discarded and the next accepted element is treated as (0,0).
- Input handshake:
  - in_ready = en & (!out_valid | out_ready). This is combinational and presents a single output register.
  - Accept = in_valid & in_ready.
- Counters, advanced on each accept only:
  - col_cnt runs 0..2*(SIZE-1), then wraps to 0 and increments row_cnt.
  - row_cnt runs 0..2*(SIZE-1), then wraps to 0 (frame boundary).
  - Counter width is $clog2(2*SIZE-1).
- Keep rule: an accepted element is kept iff row_cnt[0]==0 and col_cnt[0]==0.
  - Kept: at the next posedge, out_data<=in_data and out_valid<=1. Latency is 1 cycle from accept.
  - out_last<=1 iff row_cnt==col_cnt==2*(SIZE-1).
  - Dropped elements never touch the output register.
- Output handshake:
  - out_valid, out_data and out_last hold stable while out_valid & !out_ready.
  - If out_valid & out_ready and no new kept element arrives, out_valid clears next cycle.
  - Simultaneous drain and new kept element: the register reloads and out_valid stays 1, giving full throughput of 1 element/cycle.
- frame_done is 1 for exactly one cycle after accepting element (2*(SIZE-1),2*(SIZE-1)). Otherwise it is 0.
- en=0:
  - in_ready=0 and counters freeze.
  - The output register still drains if out_ready=1.
  - Mid-frame pauses resume at the stored position.
- Back-to-back frames: no idle cycle is required. The element after the frame wrap is (0,0) of the next frame.
- Throughput: per frame, (2*SIZE-1)^2 input beats produce SIZE^2 output beats.

Optional Feature:
Macro ZERO_UNPAD_CHECK_EN.
- Defined:
  - Any accepted dropped element (odd row or odd col) with in_data != 0 sets pad_err=1 in the next cycle.
  - pad_err stays 1 until reset.
  - The data path is unaffected.
- Not defined: no compare logic is built and pad_err is constant 0.

Test Plan:
1. SIZE=5, reset 2 cycles, en=1, out_ready=1. Stream 81 words: 3 at even/even positions, 0 elsewhere.
   -> 25 outputs, all 3. out_last only on the 25th. frame_done pulses once, one cycle after the 81st accept. pad_err=0.
2. Same stream, but even/even data = row*16+col, and out_ready toggles 1,0,1,0.
   -> Outputs appear in order 0x00,0x02,...,0x88. Data stays stable while stalled. No loss or duplication. in_ready=0 whenever out_valid & !out_ready.
3. Deassert en for 10 cycles after input element 40.
   -> in_ready=0 and counters hold during the pause. The resumed stream yields the identical 25-output sequence.
4. Assert reset after input element 30, then send a full fresh frame.
   -> All outputs clear next cycle. The following 81 words produce exactly 25 outputs starting from the new (0,0) value.
5. Two frames back-to-back: frame A kept=1, frame B kept=2.
   -> 25 ones, then 25 twos. out_last and frame_done assert once per frame.
6. With ZERO_UNPAD_CHECK_EN defined: element (1,0) carries 7.
   -> pad_err=1 from the following cycle, held through the rest of the frame. The output sequence is still correct. Without the macro, pad_err stays 0.

Source files
------------

// File: rtl/zero_unpad.sv
// rtl/zero_unpad.sv - drops zero-interleaved padding, keeping even-row/even-column samples (optional ZERO_UNPAD_CHECK_EN)
module zero_unpad #(
    parameter int SIZE   = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_done,
    output logic              pad_err
);

    localparam int CW_RAW = $clog2(2*SIZE-1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] LAST_IDX = CW'(2*(SIZE-1));

    logic [CW-1:0] row_cnt;
    logic [CW-1:0] col_cnt;
    logic          accept;
    logic          keep;
    logic          at_row_end;
    logic          at_col_end;

    // Single output register: accept a new element whenever it is empty or being drained.
    assign in_ready   = en & (~out_valid | out_ready);
    assign accept     = in_valid & in_ready;
    assign keep       = ~row_cnt[0] & ~col_cnt[0];
    assign at_row_end = (row_cnt == LAST_IDX);
    assign at_col_end = (col_cnt == LAST_IDX);

    // Raster position of the next accepted element; wraps at the end of each row and frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (accept) begin
            if (at_col_end) begin
                col_cnt <= '0;
                row_cnt <= at_row_end ? '0 : row_cnt + CW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    // Output register: loads kept elements, holds under backpressure, empties when drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (accept && keep) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= at_row_end & at_col_end;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // One-cycle pulse after the final padded element of a frame is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept & at_row_end & at_col_end;
        end
    end

`ifdef ZERO_UNPAD_CHECK_EN
    // Sticky flag: a padding position carried a non-zero value.
    always_ff @(posedge clk) begin
        if (reset) begin
            pad_err <= 1'b0;
        end else if (accept && !keep && (|in_data)) begin
            pad_err <= 1'b1;
        end
    end
`else
    assign pad_err = 1'b0;
`endif

endmodule

// File: tb/tb_zero_unpad.sv
// tb/tb_zero_unpad.sv - directed self-checking bench for zero_unpad
module tb_zero_unpad;

    localparam int SIZE = 5;
    localparam int DW   = 32;
    localparam int E    = 2*SIZE-1;
    localparam int NOUT = SIZE*SIZE;
`ifdef ZERO_UNPAD_CHECK_EN
    localparam logic PE_EXP = 1'b1;
`else
    localparam logic PE_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          frame_done;
    logic          pad_err;

    zero_unpad #(.SIZE(SIZE), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done),
        .pad_err    (pad_err)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            passes = 0;
    int            fd_cnt = 0;
    bit            tog = 0;
    logic [DW-1:0] q_data[$];
    bit            q_last[$];
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Output monitor: records transfers, frame_done pulses, and checks hold/backpressure rules.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'b0, out_valid}, 32'd1);
                chk("stall_data", out_data, prev_data);
                chk("stall_last", {31'b0, out_last}, {31'b0, prev_last});
            end
            if (out_valid && !out_ready)
                chk("in_ready_stall", {31'b0, in_ready}, 32'd0);
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_last.push_back(out_last);
            end
            if (frame_done) fd_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic send(input logic [DW-1:0] d);
        bit acc;
        int n;
        acc = 0;
        n   = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            n++;
            @(posedge clk);
            #1;
            if (tog) out_ready = ~out_ready;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            $error("FAIL send_timeout: got no in_ready expected in_ready within 200 cycles");
        end
    endtask

    function automatic logic [DW-1:0] kept_val(input int kind, input int val, input int r, input int c);
        return (kind == 1) ? DW'(r*16 + c) : DW'(val);
    endfunction

    task automatic send_frame(input int kind, input int val, input int pause_at, input int stop_at, input bit inj);
        logic [DW-1:0] d;
        int idx;
        for (int r = 0; r < E; r++) begin
            for (int c = 0; c < E; c++) begin
                idx = r*E + c;
                if (idx >= stop_at) return;
                d = (r % 2 == 0 && c % 2 == 0) ? kept_val(kind, val, r, c) : '0;
                if (inj && r == 1 && c == 0) d = 32'd7;
                if (inj && idx == 9) chk("pad_err_before", {31'b0, pad_err}, 32'd0);
                send(d);
                if (idx == 0) begin
                    chk("latency_valid", {31'b0, out_valid}, 32'd1);
                    chk("latency_data", out_data, d);
                end
                if (inj && idx == 9) chk("pad_err_after", {31'b0, pad_err}, {31'b0, PE_EXP});
                if (idx == E*E-2) chk("frame_done_early", {31'b0, frame_done}, 32'd0);
                if (idx == E*E-1) chk("frame_done_pulse", {31'b0, frame_done}, 32'd1);
                if (idx == pause_at) begin
                    en       = 1'b0;
                    in_valid = 1'b1;
                    in_data  = 32'hdead_beef;
                    for (int k = 0; k < 10; k++) begin
                        @(negedge clk);
                        chk("pause_in_ready", {31'b0, in_ready}, 32'd0);
                        @(posedge clk);
                        #1;
                    end
                    in_valid = 1'b0;
                    en       = 1'b1;
                end
            end
        end
    endtask

    task automatic drain();
        tog       = 0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input int kind, input int val);
        logic [DW-1:0] d;
        bit l;
        for (int i = 0; i < NOUT; i++) begin
            if (q_data.size() == 0) begin
                checks++;
                $error("FAIL out_missing: got %0d outputs expected %0d", i, NOUT);
                return;
            end
            d = q_data.pop_front();
            l = q_last.pop_front();
            chk("out_data", d, kept_val(kind, val, 2*(i / SIZE), 2*(i % SIZE)));
            chk("out_last", {31'b0, l}, (i == NOUT-1) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q_data.delete();
        q_last.delete();
        fd_cnt = 0;
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        do_reset();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
        chk("rst_pad_err", {31'b0, pad_err}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // 1: constant kept value, free-flowing output
        send_frame(0, 3, -1, E*E, 0);
        drain();
        chk("t1_count", q_data.size(), NOUT);
        check_frame(0, 3);
        chk("t1_frame_done_cnt", fd_cnt, 1);
        chk("t1_pad_err", {31'b0, pad_err}, 32'd0);

        // 2: positional data with toggling backpressure
        fd_cnt = 0;
        tog = 1;
        send_frame(1, 0, -1, E*E, 0);
        drain();
        chk("t2_count", q_data.size(), NOUT);
        check_frame(1, 0);
        chk("t2_frame_done_cnt", fd_cnt, 1);

        // 3: enable pause after element 40
        fd_cnt = 0;
        send_frame(1, 0, 40, E*E, 0);
        drain();
        chk("t3_count", q_data.size(), NOUT);
        check_frame(1, 0);
        chk("t3_frame_done_cnt", fd_cnt, 1);

        // 4: reset mid-frame, then a fresh frame
        send_frame(0, 4, -1, 31, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("t4_rst_data", out_data, 32'd0);
        reset = 1'b0;
        q_data.delete();
        q_last.delete();
        fd_cnt = 0;
        send_frame(0, 5, -1, E*E, 0);
        drain();
        chk("t4_count", q_data.size(), NOUT);
        check_frame(0, 5);
        chk("t4_frame_done_cnt", fd_cnt, 1);

        // 5: two frames back to back
        fd_cnt = 0;
        send_frame(0, 1, -1, E*E, 0);
        send_frame(0, 2, -1, E*E, 0);
        drain();
        chk("t5_count", q_data.size(), 2*NOUT);
        check_frame(0, 1);
        check_frame(0, 2);
        chk("t5_frame_done_cnt", fd_cnt, 2);

        // 6: non-zero padding at (1,0)
        do_reset();
        send_frame(0, 3, -1, E*E, 1);
        drain();
        chk("t6_pad_err_held", {31'b0, pad_err}, {31'b0, PE_EXP});
        chk("t6_count", q_data.size(), NOUT);
        check_frame(0, 3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
